// File: rtl/x_trela_periph_obi_slave.sv
// x_trela_periph_obi_slave: OBI register slave for CGRA control/status, kernel ID, port bases and launch FSM; optional cycle counter with X_TRELA_PERIPH_PERF_EN
module x_trela_periph_obi_slave #(
  parameter int NPORTS     = 8,
  parameter int KID_W      = 8,
  parameter int ADDR_OFF_W = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  input  logic                 cgra_done_i,
  output logic                 start_o,
  output logic [KID_W-1:0]     kernel_id_o,
  output logic [NPORTS*32-1:0] port_base_o,
  output logic                 irq_o
);
  localparam int AW = ADDR_OFF_W - 2;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;
  logic start_q, rvalid_q, irq_en_q, done_q;
  logic [31:0] rdata_q, rd_val, cnt_val, bmask;
  logic [KID_W-1:0] kid_q;
  logic [31:0] port_q [NPORTS];
  logic [AW-1:0] idx;
  logic wr, rd, launch, done_set, done_clr, unused_ok;
  assign idx = addr_i[ADDR_OFF_W-1:2];
  assign wr = req_i & we_i;
  assign rd = req_i & ~we_i;
  assign bmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign launch = wr && idx == AW'(0) && be_i[0] && wdata_i[0] && state_q == IDLE;
  assign done_set = state_q == RUN && cgra_done_i;
  assign done_clr = wr && idx == AW'(1) && be_i[0] && wdata_i[1];
  assign unused_ok = ^{addr_i[31:ADDR_OFF_W], addr_i[1:0]};
  // FSM state and launch pulse register
  always_ff @(posedge clk_i) begin
    state_q <= rst_i ? IDLE : state_d;
    start_q <= ~rst_i & launch;
  end
  // FSM next state: launch from IDLE, completion from RUN
  always_comb begin
    state_d = state_q == IDLE ? (launch ? RUN : IDLE) : (cgra_done_i ? IDLE : RUN);
  end
  // Outputs toward the bus and the CGRA core
  always_comb begin
    gnt_o = req_i;
    rvalid_o = rvalid_q;
    rdata_o = rdata_q;
    start_o = start_q;
    irq_o = done_q & irq_en_q;
    kernel_id_o = kid_q;
  end
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign port_base_o[32*g +: 32] = port_q[g];
  end
  // Read mux over the register map; unmapped offsets read 0
  always_comb begin
    rd_val = '0;
    if (idx == AW'(0)) rd_val = {30'b0, irq_en_q, 1'b0};
    if (idx == AW'(1)) rd_val = {30'b0, done_q, state_q == RUN};
    if (idx == AW'(2)) rd_val = 32'(kid_q);
    if (idx == AW'(3)) rd_val = cnt_val;
    for (int i = 0; i < NPORTS; i++) if (idx == AW'(4 + i)) rd_val = port_q[i];
  end
  // Register writes with byte enables, DONE set/clear, and the one-cycle response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      irq_en_q <= 1'b0;
      done_q <= 1'b0;
      kid_q <= '0;
      for (int i = 0; i < NPORTS; i++) port_q[i] <= '0;
    end else begin
      rvalid_q <= req_i;
      rdata_q <= rd ? rd_val : '0;
      if (wr && idx == AW'(0) && be_i[0]) irq_en_q <= wdata_i[1];
      if (done_set) done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      if (wr && idx == AW'(2)) kid_q <= (kid_q & ~bmask[KID_W-1:0]) | (wdata_i[KID_W-1:0] & bmask[KID_W-1:0]);
      for (int i = 0; i < NPORTS; i++)
        if (wr && idx == AW'(4 + i)) port_q[i] <= ((port_q[i] & ~bmask) | (wdata_i & bmask)) & ~32'h3;
    end
  end
`ifdef X_TRELA_PERIPH_PERF_EN
  logic [31:0] cnt_q;
  assign cnt_val = cnt_q;
  // Kernel cycle counter: zero during the start_o cycle, counts RUN cycles, saturates
  always_ff @(posedge clk_i) begin
    if (rst_i || launch) cnt_q <= '0;
    else if (state_q == RUN && cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
  end
`else
  assign cnt_val = '0;
`endif
endmodule

// File: tb/tb_x_trela_periph_obi_slave.sv
// tb_x_trela_periph_obi_slave: randomized scoreboard bench against a register-map reference model
module tb_x_trela_periph_obi_slave;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, dn = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0] be = '0;
  logic gnt, rvalid, start, irq;
  logic [31:0] rdata;
  logic [7:0] kid;
  logic [255:0] pb;

  x_trela_periph_obi_slave dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .cgra_done_i(dn),
    .start_o(start), .kernel_id_o(kid), .port_base_o(pb), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {bit chk; logic [31:0] d; logic [31:0] a;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  longint cyc = 0, launch_cyc = 0, start_cyc = -1, run_len = 0;
  bit m_irq_en, m_done, m_busy, exp_rv;
  logic [7:0] m_kid;
  logic [31:0] m_port [8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    exp_rv <= req & ~rst;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] cnt_exp(input longint now);
`ifdef X_TRELA_PERIPH_PERF_EN
    longint v = m_busy ? now - launch_cyc : run_len;
    if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
    return v[31:0];
`else
    return now == now ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input longint now);
    int ix = int'(a[11:2]);
    if (ix == 0) return {30'b0, m_irq_en, 1'b0};
    if (ix == 1) return {30'b0, m_done, m_busy};
    if (ix == 2) return {24'b0, m_kid};
    if (ix == 3) return cnt_exp(now);
    if (ix >= 4 && ix < 12) return m_port[ix-4];
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic void m_reset();
    m_irq_en = 0; m_done = 0; m_busy = 0; m_kid = '0; run_len = 0; start_cyc = -1;
    for (int i = 0; i < 8; i++) m_port[i] = '0;
  endfunction

  // one bus cycle: optional request, optional cgra_done pulse; model commits at the edge
  task automatic op(input bit rq, input bit w, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input bit d_n);
    longint now = cyc;
    bit busy_pre = m_busy;
    int ix = int'(a[11:2]);
    exp_t e;
    req = rq; we = w; addr = a; be = b; wdata = d; dn = d_n;
    if (rq) begin
      e.chk = !w; e.d = m_read(a, now); e.a = a;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rq && w) begin
      if (ix == 0 && b[0]) begin
        m_irq_en = d[1];
        if (d[0] && !busy_pre) begin
          m_busy = 1; launch_cyc = now + 1; start_cyc = now + 1;
        end
      end
      if (ix == 1 && b[0] && d[1]) m_done = 0;
      if (ix == 2) m_kid = merge({24'b0, m_kid}, d, b) & 32'hFF;
      if (ix >= 4 && ix < 12) m_port[ix-4] = merge(m_port[ix-4], d, b) & ~32'h3;
    end
    if (d_n && busy_pre) begin
      m_busy = 0; m_done = 1; run_len = now + 1 - launch_cyc;
    end
    #1;
    req = 0; we = 0; dn = 0;
  endtask

  task automatic rd(input logic [31:0] a); op(1, 0, a, 4'hF, 32'h0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d); op(1, 1, a, b, d, 0); endtask
  task automatic idle(input bit d_n); op(0, 0, 32'h0, 4'h0, 32'h0, d_n); endtask

  // reset with a read of STATUS presented in the same cycle; its response must never appear
  task automatic do_reset();
    rst = 1; req = 1; we = 0; addr = 32'h4; be = 4'hF;
    @(posedge clk);
    m_reset();
    #1;
    rst = 0; req = 0;
  endtask

  // monitor: handshake, pulses, level outputs and scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    check("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
    check("gnt", {31'b0, gnt}, {31'b0, req});
    check("start", {31'b0, start}, {31'b0, cyc == start_cyc});
    check("irq", {31'b0, irq}, {31'b0, m_done & m_irq_en});
    check("kernel_id", {24'b0, kid}, {24'b0, m_kid});
    if (rvalid) begin
      if (sb.size() == 0) check("unexpected_rvalid", 32'h1, 32'h0);
      else begin
        e = sb.pop_front();
        if (e.chk) check($sformatf("rdata@%h", e.a), rdata, e.d);
      end
    end
  end

  initial begin
    m_reset();
    do_reset();
    for (int a = 0; a <= 'h2C; a += 4) rd(a);
    idle(0);
    wr(32'h1C, 4'b0101, 32'hDEAD_BEEF);
    rd(32'h1C);
    rd(32'h800);
    wr(32'h8, 4'hF, 32'h5A);
    wr(32'h0, 4'h1, 32'h3);
    rd(32'h4);
    wr(32'h0, 4'h1, 32'h3);
    rd(32'h4);
    idle(1);
    rd(32'h4);
    idle(0);
    wr(32'h0, 4'h1, 32'h3);
    op(1, 1, 32'h4, 4'h1, 32'h2, 1);
    rd(32'h4);
    wr(32'h4, 4'h1, 32'h2);
    rd(32'h4);
    wr(32'h0, 4'h1, 32'h1);
    for (int i = 0; i < 100; i++) idle(0);
    rd(32'hC);
    idle(1);
    rd(32'hC);
    wr(32'h0, 4'h1, 32'h1);
    rd(32'hC);
    rd(32'hC);
    idle(0);
    do_reset();
    rd(32'h4);
    rd(32'hC);
    for (int n = 0; n < 800; n++) begin
      int r = $urandom_range(0, 15);
      logic [31:0] a = r < 12 ? 32'(r * 4) : r == 12 ? 32'h800 : ($urandom & 32'hFFFF_FFFC);
      if (r < 13) a = a | ($urandom & 32'hFFFF_F000);
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 4'($urandom), $urandom,
         $urandom_range(0, 5) == 0);
    end
    idle(0);
    idle(0);
    for (int i = 0; i < 8; i++) check($sformatf("port_base_o[%0d]", i), pb[32*i +: 32], m_port[i]);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
